inst_fetch_ctrl: RTL and testbench

- Instruction fetch sequencer placed between the byte-addressed, combinational-read instruction memory and the decode stage.
- Owns the fetch PC and drives the memory address, one 32-bit word (4 bytes) per cycle.
- Buffers fetched words with their PCs in a small prefetch FIFO.
- Hands words to decode over a valid/ready handshake; honours freeze and branch-redirect/flush.

---
 rtl/inst_fetch_ctrl.sv | 108 ++++++++++
 tb/tb_inst_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_ctrl
//  Purpose  : Instruction fetch sequencer. Owns the fetch PC, reads one
//             32-bit word per cycle from a combinational-read instruction
//             memory, buffers {word, PC} pairs in a small prefetch FIFO and
//             presents the FIFO head to decode over valid/ready. Supports
//             freeze (fetch stall) and branch redirect (flush + PC reload).
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             imem_addr         - byte address to instruction memory (= PC)
//             imem_data         - instruction word for imem_addr
//             freeze            - stall fetch; head may still drain
//             branch_taken      - flush FIFO and reload PC from branch_addr
//             branch_addr       - redirect target (low 2 bits ignored)
//             inst_valid        - FIFO head holds a valid instruction
//             inst, inst_pc     - head instruction and its byte address
//             inst_ready        - decode accepts head this cycle
//             fifo_count        - FIFO occupancy, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
    parameter int INST_LEN = 32,
    parameter int MEM_SIZE = 2048,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    output logic [INST_LEN-1:0] imem_addr,
    input  logic [INST_LEN-1:0] imem_data,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [INST_LEN-1:0] branch_addr,
    output logic                inst_valid,
    output logic [INST_LEN-1:0] inst,
    output logic [INST_LEN-1:0] inst_pc,
    input  logic                inst_ready,
    output logic [CNT_W-1:0]    fifo_count
);

    localparam int                c_PTR_W      = $clog2(DEPTH);
    // MEM_SIZE is a power of two, so "mod MEM_SIZE" is a simple AND mask.
    localparam logic [INST_LEN-1:0] c_ADDR_MASK  = INST_LEN'(MEM_SIZE - 1);
    localparam logic [INST_LEN-1:0] c_ALIGN_MASK = c_ADDR_MASK & ~(INST_LEN'(3));
    localparam logic [INST_LEN-1:0] c_PC_STEP    = INST_LEN'(4);
    localparam logic [CNT_W-1:0]    c_DEPTH      = CNT_W'(DEPTH);

    logic [INST_LEN-1:0] r_pc;
    logic [INST_LEN-1:0] r_mem_inst [DEPTH];
    logic [INST_LEN-1:0] r_mem_pc   [DEPTH];
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]    r_count;

    logic                w_deq;
    logic                w_enq;
    logic [INST_LEN-1:0] w_pc_seq;
    logic [INST_LEN-1:0] w_pc_branch;

    assign w_deq       = (r_count != '0) & inst_ready;
    // A full FIFO may still accept a word when the head leaves this cycle.
    assign w_enq       = ~freeze & ~branch_taken & ((r_count < c_DEPTH) | w_deq);
    assign w_pc_seq    = (r_pc + c_PC_STEP) & c_ADDR_MASK;
    assign w_pc_branch = branch_addr & c_ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            // Cleared so inst/inst_pc read as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (branch_taken) begin
            // Flush discards any same-cycle enqueue or dequeue.
            r_pc    <= w_pc_branch;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_mem_inst[r_tail] <= imem_data;
                r_mem_pc[r_tail]   <= r_pc;
                r_tail             <= r_tail + c_PTR_W'(1);
                r_pc               <= w_pc_seq;
            end
            if (w_deq) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign inst_valid = (r_count != '0);
    assign inst       = r_mem_inst[r_head];
    assign inst_pc    = r_mem_pc[r_head];
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_ctrl
//  Purpose  : Self-checking bench for inst_fetch_ctrl. A queue-based model of
//             the prefetch buffer and fetch PC tracks expected outputs;
//             directed scenarios plus a randomized run compare against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

    localparam int MEM_SIZE = 2048;
    localparam int DEPTH    = 4;
    localparam int NWORDS   = MEM_SIZE / 4;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [2:0]  fifo_count;

    logic [31:0] mem [NWORDS];
    logic [8:0]  w_idx;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mpc;

    inst_fetch_ctrl #(
        .INST_LEN(32), .MEM_SIZE(MEM_SIZE), .DEPTH(DEPTH), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .fifo_count(fifo_count)
    );

    assign w_idx     = 9'((imem_addr >> 2) % 32'(NWORDS));
    assign imem_data = mem[w_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO as a queue, PC as plain arithmetic.
    task automatic model_update(input logic r, input logic f, input logic b,
                                input logic [31:0] ba, input logic rd);
        bit d, e;
        if (r) begin
            q.delete();
            mpc = 0;
        end else if (b) begin
            q.delete();
            mpc = ((ba / 4) * 4) % MEM_SIZE;
        end else begin
            d = (q.size() > 0) && rd;
            e = !f && ((q.size() < DEPTH) || d);
            if (d) void'(q.pop_front());
            if (e) begin
                q.push_back({mem[mpc / 4], mpc});
                mpc = (mpc + 4) % MEM_SIZE;
            end
        end
    endtask

    // Apply one cycle of inputs (from a negedge), return at the next negedge.
    task automatic step(input logic r, input logic f, input logic b,
                        input logic [31:0] ba, input logic rd);
        rst = r; freeze = f; branch_taken = b; branch_addr = ba; inst_ready = rd;
        @(posedge clk);
        model_update(r, f, b, ba, rd);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 32'h100, 1);
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h want 0", inst); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 4; i++) mem[i] = 32'hE3A00014;
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'hE3A00014 || inst_pc !== 32'h0) begin
            n_err++; $display("FAIL free_first: got v=%b inst=%h pc=%h want v=1 inst=e3a00014 pc=0", inst_valid, inst, inst_pc);
        end
        for (int i = 1; i < 8; i++) begin
            step(0, 0, 0, 0, 1);
            n_cmp++; if (inst_pc !== 32'(4 * i) || fifo_count !== 3'd1 || inst !== mem[i]) begin
                n_err++; $display("FAIL free_step%0d: got pc=%h cnt=%0d inst=%h want pc=%h cnt=1 inst=%h",
                                  i, inst_pc, fifo_count, inst, 4 * i, mem[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        n_cmp++; if (fifo_count !== 3'd4 || imem_addr !== 32'd16 || inst_pc !== 32'd0) begin
            n_err++; $display("FAIL bp_full: got cnt=%0d addr=%0d pc=%0d want cnt=4 addr=16 pc=0", fifo_count, imem_addr, inst_pc);
        end
        step(0, 0, 0, 0, 1);
        n_cmp++; if (fifo_count !== 3'd4 || imem_addr !== 32'd20 || inst_pc !== 32'd4) begin
            n_err++; $display("FAIL bp_pop_push: got cnt=%0d addr=%0d pc=%0d want cnt=4 addr=20 pc=4", fifo_count, imem_addr, inst_pc);
        end
    endtask

    task automatic test_branch();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL br_pre_count: got %0d want 3", fifo_count); end
        step(0, 0, 1, 32'h3E, 1);
        n_cmp++; if (fifo_count !== 3'd0 || inst_valid !== 1'b0 || imem_addr !== 32'h3C) begin
            n_err++; $display("FAIL br_flush: got cnt=%0d v=%b addr=%h want cnt=0 v=0 addr=3c", fifo_count, inst_valid, imem_addr);
        end
        step(0, 0, 0, 0, 1);
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3C || inst !== mem[15]) begin
            n_err++; $display("FAIL br_target: got v=%b pc=%h inst=%h want v=1 pc=3c inst=%h", inst_valid, inst_pc, inst, mem[15]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'd2040; exp_pc[1] = 32'd2044; exp_pc[2] = 32'd0; exp_pc[3] = 32'd4;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 32'd2040, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        n_cmp++; if (fifo_count !== 3'd4 || imem_addr !== 32'd8) begin
            n_err++; $display("FAIL wrap_fill: got cnt=%0d addr=%0d want cnt=4 addr=8", fifo_count, imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (inst_pc !== exp_pc[i] || inst !== mem[exp_pc[i] / 4]) begin
                n_err++; $display("FAIL wrap_order%0d: got pc=%0d inst=%h want pc=%0d inst=%h",
                                  i, inst_pc, inst, exp_pc[i], mem[exp_pc[i] / 4]);
            end
            step(0, 1, 0, 0, 1);
        end
    endtask

    task automatic test_freeze_reset();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        n_cmp++; if (fifo_count !== 3'd1 || imem_addr !== 32'd8 || inst_pc !== 32'd4) begin
            n_err++; $display("FAIL frz_drain1: got cnt=%0d addr=%0d pc=%0d want cnt=1 addr=8 pc=4", fifo_count, imem_addr, inst_pc);
        end
        step(0, 1, 0, 0, 1);
        n_cmp++; if (fifo_count !== 3'd0 || inst_valid !== 1'b0 || imem_addr !== 32'd8) begin
            n_err++; $display("FAIL frz_drain2: got cnt=%0d v=%b addr=%0d want cnt=0 v=0 addr=8", fifo_count, inst_valid, imem_addr);
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h200, 0);
        n_cmp++; if (imem_addr !== 32'h200 || fifo_count !== 3'd0) begin
            n_err++; $display("FAIL frz_branch: got addr=%h cnt=%0d want addr=200 cnt=0", imem_addr, fifo_count);
        end
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h300, 1);
        n_cmp++; if (imem_addr !== 32'h0 || fifo_count !== 3'd0 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_vs_branch: got addr=%h cnt=%0d v=%b want addr=0 cnt=0 v=0", imem_addr, fifo_count, inst_valid);
        end
    endtask

    task automatic test_random();
        logic r, f, b, rd;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(63) == 0);
            f  = ($urandom_range(3) == 0);
            b  = ($urandom_range(15) == 0);
            rd = ($urandom_range(2) != 0);
            step(r, f, b, $urandom, rd);
            n_cmp++; if (imem_addr !== mpc) begin
                n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", i, imem_addr, mpc);
            end
            n_cmp++; if (int'(fifo_count) !== q.size() || inst_valid !== (q.size() > 0)) begin
                n_err++; $display("FAIL rnd_count@%0d: got cnt=%0d v=%b want cnt=%0d", i, fifo_count, inst_valid, q.size());
            end
            if (q.size() > 0) begin
                n_cmp++; if (inst !== q[0].w || inst_pc !== q[0].pc) begin
                    n_err++; $display("FAIL rnd_head@%0d: got inst=%h pc=%h want inst=%h pc=%h", i, inst, inst_pc, q[0].w, q[0].pc);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; inst_ready = 1'b0;
        mpc = 0;
        for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_backpressure();
        test_branch();
        test_wrap();
        test_freeze_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
